td4x_core: RTL and testbench
============================

# td4x_core

Parametrised successor to the 4-bit TD4 CPU core, with W-bit data and AW-bit program counter. Single-cycle fetch/execute from an external combinational program ROM. Adds over TD4:
- a built-in ALU;
- valid/ready handshakes on the input and output ports;
- JC, ADD A,B, NOP and HLT instructions;
- a halt state.

Sits under the top level; ROM, input source and output sink are external.

## Interface
Parameters:
- W, 4, data width (A, B, ports, ALU), ≥ 2
- AW, 4, program-counter width, ≥ 2
- IW, max(W,AW), immediate field width; derived, not overridable

Ports:
- CLK  in  1  clock, rising edge
- CLR  in  1  reset, asynchronous, active-low
- EN  in  1  clock enable; low freezes all state
- rom_addr  out  AW  program counter
- rom_data  in  4+IW  instruction {opcode[3:0], imm[IW-1:0]}, combinational from rom_addr
- in_data  in  W  input port data
- in_valid  in  1  in_data valid
- in_ready  out  1  core consumes in_data this cycle
- out_data  out  W  output port register
- out_valid  out  1  out_data holds an unconsumed value
- out_ready  in  1  sink accepts out_data
- carry  out  1  carry flag
- halted  out  1  core is in HALT

## Operation
- Registers: A, B (W bits), PC (AW), carry, out_data, out_valid, state ∈ {RUN, HALT}.
- Reset values: all registers 0, state RUN, in_ready 0.
- Immediate use: data ops take imm[W-1:0]; jumps take imm[AW-1:0].
- Opcodes (carry ← ALU carry-out for ADD ops; carry ← 0 for every other executed op):
  - 0000 ADD A,Im
  - 0101 ADD B,Im
  - 1100 ADD A,B (result to A)
  - 0011 MOV A,Im
  - 0111 MOV B,Im
  - 0001 MOV A,B
  - 0100 MOV B,A
  - 0010 IN A
  - 0110 IN B
  - 1001 OUT B
  - 1011 OUT Im
  - 1111 JMP Im
  - 1110 JNC Im (jump if carry=0)
  - 1101 JC Im (jump if carry=1)
  - 1000 HLT
  - 1010 NOP
- Condition test: JNC/JC read carry as it stands before the jump executes, then clear it.
- Arithmetic: sum is W+1 bits; result = sum[W-1:0], carry-out = sum[W].
- PC: ← imm on a taken jump, else PC+1 modulo 2^AW.
- IN: in_ready = EN & RUN & opcode is IN. Executes only when in_valid=1; otherwise stalls.
- OUT: executes when out_valid=0 or out_ready=1; otherwise stalls. On execute, out_data ← value and out_valid ← 1.
- Output drain: with no OUT executing, out_valid & out_ready → out_valid ← 0.
- Stall: PC, A, B, carry, out_data unchanged; the handshake signals stay live.
- HLT: state ← HALT, PC not incremented, carry ← 0. HALT is left only by reset. The output side still drains in HALT.
- EN=0: no register changes, in_ready=0; a pending out_valid is not cleared.

## Timing
- Non-stalling instruction: 1 cycle; results visible the next cycle.
- rom_addr is the registered PC; rom_data is sampled in the same cycle.
- in_ready is combinational from rom_data, state and EN. out_valid, out_data, carry and halted are registered.
- Simultaneous drain and new OUT in one cycle: new value loaded, out_valid stays 1.
- Reset mid-stall or in HALT: immediate return to reset values.

## Structure
- td4x_pkg: opcode localparams and the state enum.
- Sub-module td4x_alu: W-bit adder with carry-out, operand select (A, B, in_data, zero) plus immediate.

## Test plan
- Reset: CLR=0 pulse → rom_addr=0, out_data=0, out_valid=0, carry=0, halted=0.
- Carry/jumps (W=4): MOV A,3; ADD A,14 → A=1, carry=1. JNC 9 falls through with carry cleared. Then ADD A,15; JC 12 → rom_addr=12.
- Output backpressure: OUT Im 5 with out_ready=0 → out_data=5, out_valid=1. Following OUT B holds rom_addr until out_ready=1 that cycle. Then out_data=B, out_valid=1.
- Input handshake: IN A with in_valid=0 for 3 cycles → rom_addr held, in_ready=1. Then in_valid=1, in_data=9 → A=9, PC+1.
- Wrap and enable (AW=4): NOP at address 15 → rom_addr=0. EN=0 for 2 cycles → no state change.
- Halt: HLT at address 6 → halted=1, rom_addr=6 for 10 cycles, pending out_valid drains on out_ready. Then CLR → halted=0, rom_addr=0.

Source files
------------

// File: rtl/td4x_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// td4x_pkg: opcode encodings, core state and ALU operand-select types. Rev 1.0
// ---------------------------------------------------------------------------
package td4x_pkg;

  localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [3:0] OP_IN_A     = 4'b0010;
  localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [3:0] OP_IN_B     = 4'b0110;
  localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [3:0] OP_HLT      = 4'b1000;
  localparam logic [3:0] OP_OUT_B    = 4'b1001;
  localparam logic [3:0] OP_NOP      = 4'b1010;
  localparam logic [3:0] OP_OUT_IM   = 4'b1011;
  localparam logic [3:0] OP_ADD_A_B  = 4'b1100;
  localparam logic [3:0] OP_JC       = 4'b1101;
  localparam logic [3:0] OP_JNC      = 4'b1110;
  localparam logic [3:0] OP_JMP      = 4'b1111;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_t;

endpackage
`default_nettype wire

// File: rtl/td4x_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// td4x_alu: selected operand plus addend, W-bit result with carry-out. Rev 1.0
// ---------------------------------------------------------------------------
module td4x_alu
  import td4x_pkg::*;
#(
  parameter int W = 4
) (
  input  src_t         src,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] addend,
  output logic [W-1:0] result,
  output logic         carry_out
);

  logic [W-1:0] operand;
  logic [W:0]   sum;

  always_comb begin
    operand = '0;
    case (src)
      SRC_A:   operand = a;
      SRC_B:   operand = b;
      SRC_IN:  operand = in_data;
      default: operand = '0;
    endcase
  end

  assign sum       = {1'b0, operand} + {1'b0, addend};
  assign result    = sum[W-1:0];
  assign carry_out = sum[W];

endmodule
`default_nettype wire

// File: rtl/td4x_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// td4x_core: TD4-style single-cycle CPU with valid/ready I/O and halt. Rev 1.0
// ---------------------------------------------------------------------------
module td4x_core
  import td4x_pkg::*;
#(
  parameter int W  = 4,
  parameter int AW = 4,
  localparam int IW = (W > AW) ? W : AW
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic           EN,
  output logic [AW-1:0]  rom_addr,
  input  logic [4+IW-1:0] rom_data,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           carry,
  output logic           halted
);

  state_t        state, state_nxt;
  logic [W-1:0]  a, a_nxt, b, b_nxt, od_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic          carry_nxt, ov_nxt;

  logic [3:0]    opcode;
  logic [W-1:0]  imm_w;
  logic [AW-1:0] imm_pc;
  logic          is_in, is_out, stall, out_load;

  src_t          src;
  logic [W-1:0]  addend, result;
  logic          carry_out;

  assign opcode = rom_data[4+IW-1:IW];
  assign imm_w  = rom_data[W-1:0];
  assign imm_pc = rom_data[AW-1:0];
  assign is_in  = (opcode == OP_IN_A) || (opcode == OP_IN_B);
  assign is_out = (opcode == OP_OUT_B) || (opcode == OP_OUT_IM);
  assign stall  = (is_in && !in_valid) || (is_out && out_valid && !out_ready);

  // Gated by CLR so the port reads 0 while the core is held in reset.
  assign in_ready = EN && CLR && (state == ST_RUN) && is_in;

  assign rom_addr = pc;
  assign halted   = (state == ST_HALT);

  // Every data move goes through the adder; plain moves add zero.
  always_comb begin
    src    = SRC_ZERO;
    addend = imm_w;
    case (opcode)
      OP_ADD_A_IM:        src = SRC_A;
      OP_ADD_B_IM:        src = SRC_B;
      OP_ADD_A_B: begin   src = SRC_A;  addend = b;  end
      OP_MOV_A_B,
      OP_OUT_B:   begin   src = SRC_B;  addend = '0; end
      OP_MOV_B_A: begin   src = SRC_A;  addend = '0; end
      OP_IN_A,
      OP_IN_B:    begin   src = SRC_IN; addend = '0; end
      default:            src = SRC_ZERO;
    endcase
  end

  td4x_alu #(.W(W)) u_alu (
    .src       (src),
    .a         (a),
    .b         (b),
    .in_data   (in_data),
    .addend    (addend),
    .result    (result),
    .carry_out (carry_out)
  );

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    pc_nxt    = pc;
    carry_nxt = carry;
    od_nxt    = out_data;
    ov_nxt    = out_valid;
    out_load  = 1'b0;
    if (EN) begin
      if (state == ST_RUN && !stall) begin
        pc_nxt    = pc + 1'b1;
        carry_nxt = 1'b0;
        case (opcode)
          OP_ADD_A_IM,
          OP_ADD_A_B:  begin a_nxt = result; carry_nxt = carry_out; end
          OP_ADD_B_IM: begin b_nxt = result; carry_nxt = carry_out; end
          OP_MOV_A_IM,
          OP_MOV_A_B,
          OP_IN_A:     a_nxt = result;
          OP_MOV_B_IM,
          OP_MOV_B_A,
          OP_IN_B:     b_nxt = result;
          OP_OUT_B,
          OP_OUT_IM:   begin od_nxt = result; out_load = 1'b1; end
          OP_JMP:      pc_nxt = imm_pc;
          OP_JNC:      if (!carry) pc_nxt = imm_pc;
          OP_JC:       if (carry) pc_nxt = imm_pc;
          OP_HLT:      begin pc_nxt = pc; state_nxt = ST_HALT; end
          default:     ;
        endcase
      end
      // A new OUT wins over a same-cycle drain, so out_valid stays set.
      if (out_load)
        ov_nxt = 1'b1;
      else if (out_valid && out_ready)
        ov_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state     <= ST_RUN;
      a         <= '0;
      b         <= '0;
      pc        <= '0;
      carry     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      pc        <= pc_nxt;
      carry     <= carry_nxt;
      out_data  <= od_nxt;
      out_valid <= ov_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_td4x_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_td4x_core: random programs against an instruction-level model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_td4x_core;

  localparam int W  = 4;
  localparam int AW = 4;
  localparam int DM = (1 << W) - 1;
  localparam int PM = (1 << AW) - 1;

  logic          CLK = 1'b0;
  logic          CLR = 1'b0;
  logic          EN = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          carry;
  logic          halted;

  logic [7:0]    rom [16];

  int passed = 0;
  int total  = 0;

  // Instruction-level model state
  int ma, mb, mpc, mc, mod, mov, mh;

  always #5 CLK = ~CLK;

  assign rom_data = rom[rom_addr];

  td4x_core #(.W(W), .AW(AW)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .EN        (EN),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .carry     (carry),
    .halted    (halted)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic model_reset();
    ma = 0; mb = 0; mpc = 0; mc = 0; mod = 0; mov = 0; mh = 0;
  endtask

  // Asynchronous reset: outputs are checked before any clock edge arrives.
  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b0;
    #1;
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    model_reset();
    @(posedge CLK);
    #1;
    CLR = 1'b1;
  endtask

  // One clock: drive inputs, compare DUT to model, advance the model.
  task automatic cycle(input bit en, input bit iv, input int ind, input bit ordy);
    int op, imm, s;
    bit drain, loaded;
    @(negedge CLK);
    EN = en; in_valid = iv; in_data = ind[W-1:0]; out_ready = ordy;
    #1;
    op  = int'(rom[mpc[AW-1:0]]) >> 4;
    imm = int'(rom[mpc[AW-1:0]]) & 15;
    chk("rom_addr", int'(rom_addr), mpc);
    chk("out_data", int'(out_data), mod);
    chk("out_valid", int'(out_valid), mov);
    chk("carry", int'(carry), mc);
    chk("halted", int'(halted), mh);
    chk("in_ready", int'(in_ready), int'(en && !mh && (op == 2 || op == 6)));
    if (en) begin
      drain  = (mov != 0) && ordy;
      loaded = 0;
      if (!mh) begin
        case (op)
          0:  begin s = ma + (imm & DM); ma = s & DM; mc = s >> W; mpc++; end
          5:  begin s = mb + (imm & DM); mb = s & DM; mc = s >> W; mpc++; end
          12: begin s = ma + mb; ma = s & DM; mc = s >> W; mpc++; end
          3:  begin ma = imm & DM; mc = 0; mpc++; end
          7:  begin mb = imm & DM; mc = 0; mpc++; end
          1:  begin ma = mb; mc = 0; mpc++; end
          4:  begin mb = ma; mc = 0; mpc++; end
          2:  if (iv) begin ma = ind & DM; mc = 0; mpc++; end
          6:  if (iv) begin mb = ind & DM; mc = 0; mpc++; end
          9, 11: if (!mov || ordy) begin
                mod = (op == 9) ? mb : (imm & DM); loaded = 1; mc = 0; mpc++;
              end
          15: begin mpc = imm & PM; mc = 0; end
          14: begin mpc = mc ? mpc + 1 : (imm & PM); mc = 0; end
          13: begin mpc = mc ? (imm & PM) : mpc + 1; mc = 0; end
          8:  begin mh = 1; mc = 0; end
          default: begin mc = 0; mpc++; end
        endcase
        mpc = mpc & PM;
      end
      if (loaded) mov = 1;
      else if (drain) mov = 0;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int op;
    // Directed program: carry, jumps, backpressure, input stall, halt.
    for (int i = 0; i < 16; i++) rom[i] = 8'hA0;
    rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE9; rom[3] = 8'h0F;
    rom[4] = 8'hDC; rom[12] = 8'hB5; rom[13] = 8'h90; rom[14] = 8'h20;
    rom[15] = 8'h80;
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("lit_add_carry", int'(carry), 1);
    chk("lit_add_pc", int'(rom_addr), 2);
    cycle(1, 0, 0, 0);
    chk("lit_jnc_fall_pc", int'(rom_addr), 3);
    chk("lit_jnc_clears", int'(carry), 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("lit_jc_taken", int'(rom_addr), 12);
    cycle(1, 0, 0, 0);
    chk("lit_out_im_data", int'(out_data), 5);
    chk("lit_out_im_valid", int'(out_valid), 1);
    cycle(1, 0, 0, 0);
    chk("lit_out_stall_pc", int'(rom_addr), 13);
    cycle(0, 0, 0, 1);
    chk("lit_en0_hold_valid", int'(out_valid), 1);
    cycle(1, 0, 0, 1);
    chk("lit_out_b_data", int'(out_data), 0);
    chk("lit_out_b_pc", int'(rom_addr), 14);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    chk("lit_in_stall_pc", int'(rom_addr), 14);
    cycle(1, 1, 9, 0);
    chk("lit_in_pc", int'(rom_addr), 15);
    cycle(1, 0, 0, 1);
    chk("lit_halted", int'(halted), 1);
    chk("lit_halt_drain", int'(out_valid), 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    chk("lit_halt_pc", int'(rom_addr), 15);

    // Random programs with random handshakes, enables and resets.
    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < 16; i++) begin
        op = $urandom_range(0, 15);
        if (op == 8 && $urandom_range(0, 3) != 0) op = 10;
        rom[i] = {op[3:0], 4'($urandom_range(0, 15))};
      end
      do_reset();
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 99) == 0) do_reset();
        else cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0,
                   int'($urandom_range(0, DM)), $urandom_range(0, 1) != 0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
